// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding, priority-mode constants and width helper for the Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANTED, DRAIN} arb_state_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    function automatic int safe_clog2(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// rr_picker: combinational one-hot winner select, round-robin after ptr_i or fixed lowest-index.
module rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]               req_i,
    input  logic [safe_clog2(N)-1:0]   ptr_i,
    input  logic                       mode_i,
    output logic [N-1:0]               gnt_o
);

    int best;
    int rank;

    // rank 0 is highest priority: index j in fixed mode, distance past ptr_i in round-robin
    always_comb begin
        gnt_o = '0;
        best  = N;
        rank  = 0;
        for (int j = 0; j < N; j++) begin
            rank = mode_i ? j : (j + N - 1 - int'(ptr_i)) % N;
            if (req_i[j] && rank < best) begin
                best     = rank;
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: N-master to 1-slave pipelined Wishbone arbiter with cycle-long grant,
// outstanding-strobe limiting and a hung-cycle watchdog.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 30,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PRIORITY_MODE   = 0,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_MASTERS-1:0]                  i_m_cyc,
    input  logic [NUM_MASTERS-1:0]                  i_m_stb,
    input  logic [NUM_MASTERS-1:0]                  i_m_we,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]   i_m_sel,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]       i_m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]       i_m_data,
    output logic [NUM_MASTERS-1:0]                  o_m_ack,
    output logic [NUM_MASTERS-1:0]                  o_m_stall,
    output logic [DATA_WIDTH-1:0]                   o_m_data,
    output logic                                    o_wb_cyc,
    output logic                                    o_wb_stb,
    output logic                                    o_wb_we,
    output logic [DATA_WIDTH/8-1:0]                 o_wb_sel,
    output logic [ADDR_WIDTH-1:0]                   o_wb_addr,
    output logic [DATA_WIDTH-1:0]                   o_wb_data,
    input  logic                                    i_wb_ack,
    input  logic                                    i_wb_stall,
    input  logic [DATA_WIDTH-1:0]                   i_wb_data,
    output logic [NUM_MASTERS-1:0]                  o_grant,
    output logic                                    o_timeout
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int PW = safe_clog2(NUM_MASTERS);
    localparam int OW = safe_clog2(MAX_OUTSTANDING + 1);
    localparam int TW = safe_clog2(TIMEOUT_CYCLES + 1);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d, win;
    logic [PW-1:0]          ptr_q, ptr_d, win_idx;
    logic [OW-1:0]          cnt_q, cnt_d;
    logic [TW-1:0]          wd_q, wd_d;
    logic                   timeout_q, timeout_d;
    logic                   m_cyc, m_stb, m_we;
    logic [SW-1:0]          m_sel;
    logic [ADDR_WIDTH-1:0]  m_addr;
    logic [DATA_WIDTH-1:0]  m_data;
    logic                   granted, full, ack_fwd, inc, wd_hit;

    rr_picker #(.N(NUM_MASTERS)) u_picker (
        .req_i  (i_m_cyc),
        .ptr_i  (ptr_q),
        .mode_i (PRIORITY_MODE == PRIO_FIXED),
        .gnt_o  (win)
    );

    always_comb begin
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_sel   = '0;
        m_addr  = '0;
        m_data  = '0;
        win_idx = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                m_cyc  = i_m_cyc[k];
                m_stb  = i_m_stb[k];
                m_we   = i_m_we[k];
                m_sel  = i_m_sel[k*SW +: SW];
                m_addr = i_m_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                m_data = i_m_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
            if (win[k]) win_idx = PW'(k);
        end
    end

    assign granted   = state_q == GRANTED;
    assign full      = cnt_q == OW'(MAX_OUTSTANDING);
    assign o_wb_cyc  = granted & m_cyc;
    assign o_wb_stb  = o_wb_cyc & m_stb & ~full;
    assign o_wb_we   = granted & m_we;
    assign o_wb_sel  = granted ? m_sel : '0;
    assign o_wb_addr = granted ? m_addr : '0;
    assign o_wb_data = granted ? m_data : '0;
    // acks arriving with nothing outstanding, or after the slave saw cyc drop, are discarded
    assign ack_fwd   = o_wb_cyc & i_wb_ack & (cnt_q != '0);
    assign inc       = o_wb_stb & ~i_wb_stall;
    assign wd_hit    = (TIMEOUT_CYCLES != 0) && (wd_q == TW'(TIMEOUT_CYCLES - 1));
    assign o_m_ack   = ack_fwd ? grant_q : '0;
    assign o_m_stall = granted ? (~grant_q | {NUM_MASTERS{i_wb_stall | full}}) : '1;
    assign o_m_data  = i_wb_data;
    assign o_grant   = grant_q;
    assign o_timeout = timeout_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                wd_d  = '0;
                if (|i_m_cyc) begin
                    state_d = GRANTED;
                    grant_d = win;
                    ptr_d   = win_idx;
                end
            end
            GRANTED: begin
                if (!m_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    wd_d    = '0;
                end else if (wd_hit && cnt_q != '0 && !ack_fwd) begin
                    state_d   = DRAIN;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    wd_d      = '0;
                end else begin
                    cnt_d = cnt_q + OW'(inc) - OW'(ack_fwd);
                    wd_d  = (ack_fwd || cnt_q == '0) ? '0 : wd_q + TW'(1);
                end
            end
            DRAIN: begin
                if (!m_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= PW'(NUM_MASTERS - 1);
            cnt_q     <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: vector table, directed corner sequences and a randomized run against a reference model.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [7:0]  m_sel;
    logic [59:0] m_addr;
    logic [63:0] m_data;
    logic        wb_ack, wb_stall;
    logic [31:0] wb_rdata;

    logic [1:0]  rr_ack, rr_stall, rr_grant, fx_ack, fx_stall, fx_grant;
    logic [31:0] rr_mdata, fx_mdata, rr_wdata, fx_wdata;
    logic        rr_cyc, rr_stb, rr_we, rr_to, fx_cyc, fx_stb, fx_we, fx_to;
    logic [3:0]  rr_sel, fx_sel;
    logic [29:0] rr_addr, fx_addr;

    always #5 clk = ~clk;

    wb_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(30), .DATA_WIDTH(32), .MAX_OUTSTANDING(4),
                 .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) dut_rr (
        .clk(clk), .reset(reset), .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
        .i_m_sel(m_sel), .i_m_addr(m_addr), .i_m_data(m_data), .o_m_ack(rr_ack),
        .o_m_stall(rr_stall), .o_m_data(rr_mdata), .o_wb_cyc(rr_cyc), .o_wb_stb(rr_stb),
        .o_wb_we(rr_we), .o_wb_sel(rr_sel), .o_wb_addr(rr_addr), .o_wb_data(rr_wdata),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_data(wb_rdata),
        .o_grant(rr_grant), .o_timeout(rr_to));

    wb_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(30), .DATA_WIDTH(32), .MAX_OUTSTANDING(4),
                 .PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)) dut_fx (
        .clk(clk), .reset(reset), .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
        .i_m_sel(m_sel), .i_m_addr(m_addr), .i_m_data(m_data), .o_m_ack(fx_ack),
        .o_m_stall(fx_stall), .o_m_data(fx_mdata), .o_wb_cyc(fx_cyc), .o_wb_stb(fx_stb),
        .o_wb_we(fx_we), .o_wb_sel(fx_sel), .o_wb_addr(fx_addr), .o_wb_data(fx_wdata),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_data(wb_rdata),
        .o_grant(fx_grant), .o_timeout(fx_to));

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: who owns the bus, whether it is draining, strobes in flight, idle-ack age
    bit md_busy, md_drain, md_to;
    int md_own, md_last, md_out, md_wd;

    task automatic md_reset();
        md_busy = 0; md_drain = 0; md_to = 0; md_own = 0; md_last = 1; md_out = 0; md_wd = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_addr = '0; m_data = '0;
        wb_ack = 1'b0; wb_stall = 1'b0; wb_rdata = '0;
        tick();
        reset = 1'b0;
        md_reset();
    endtask

    task automatic model_step();
        bit gr, full, wc, ws, fwd, found;
        logic [1:0] eg, es;
        gr   = md_busy && !md_drain;
        full = md_out == 4;
        eg   = md_busy ? 2'(1 << md_own) : 2'b00;
        wc   = gr && m_cyc[md_own];
        ws   = wc && m_stb[md_own] && !full;
        fwd  = wc && wb_ack && md_out > 0;
        es   = 2'b11;
        if (gr && !(wb_stall || full)) es[md_own] = 1'b0;
        chk("rnd_grant", rr_grant, eg);
        chk("rnd_wb_cyc", rr_cyc, wc);
        chk("rnd_wb_stb", rr_stb, ws);
        chk("rnd_m_ack", rr_ack, fwd ? eg : 2'b00);
        chk("rnd_m_stall", rr_stall, es);
        chk("rnd_timeout", rr_to, md_to);
        chk("rnd_m_data", rr_mdata, wb_rdata);
        if (!md_drain) begin
            chk("rnd_wb_addr", rr_addr, gr ? m_addr[md_own*30 +: 30] : 30'h0);
            chk("rnd_wb_data", rr_wdata, gr ? m_data[md_own*32 +: 32] : 32'h0);
            chk("rnd_wb_sel", rr_sel, gr ? m_sel[md_own*4 +: 4] : 4'h0);
            chk("rnd_wb_we", rr_we, gr ? m_we[md_own] : 1'b0);
        end
        md_to = 0;
        if (reset) md_reset();
        else if (!md_busy) begin
            found = 0;
            for (int i = 1; i <= 2; i++) begin
                if (!found && m_cyc[(md_last + i) % 2]) begin
                    found = 1; md_own = (md_last + i) % 2;
                end
            end
            if (found) begin md_busy = 1; md_last = md_own; md_out = 0; md_wd = 0; end
        end else if (md_drain) begin
            if (!m_cyc[md_own]) begin md_busy = 0; md_drain = 0; end
        end else if (!m_cyc[md_own]) begin
            md_busy = 0; md_out = 0; md_wd = 0;
        end else if (md_out > 0 && !fwd && md_wd == 7) begin
            md_drain = 1; md_to = 1; md_out = 0; md_wd = 0;
        end else begin
            md_wd  = (fwd || md_out == 0) ? 0 : md_wd + 1;
            md_out = md_out + int'(ws && !wb_stall) - int'(fwd);
        end
    endtask

    typedef struct {
        logic [1:0]  cyc, stb;
        logic        ack, stl;
        logic [1:0]  grant;
        logic        wcyc, wstb;
        logic [1:0]  mack, mstall;
        logic [29:0] addr;
    } vec_t;

    vec_t vecs [18];
    logic [1:0] g;

    initial begin
        // single read by master0, then master1 pipelines past the outstanding limit
        vecs = '{
            '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 30'h00},
            '{2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 30'h00},
            '{2'b01, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b10, 30'h10},
            '{2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 2'b10, 30'h10},
            '{2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b10, 30'h10},
            '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 30'h00},
            '{2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 30'h00},
            '{2'b10, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b01, 30'h20},
            '{2'b10, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b01, 30'h20},
            '{2'b10, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b01, 30'h20},
            '{2'b10, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b01, 30'h20},
            '{2'b10, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 2'b11, 30'h20},
            '{2'b10, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 2'b11, 30'h20},
            '{2'b10, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 2'b10, 2'b11, 30'h20},
            '{2'b10, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b01, 30'h20},
            '{2'b10, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 2'b11, 30'h20},
            '{2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b11, 30'h20},
            '{2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 30'h00}
        };
        do_reset();
        #1;
        chk("rst_grant", rr_grant, 2'b00);
        chk("rst_stall", rr_stall, 2'b11);
        chk("rst_wb_cyc", rr_cyc, 1'b0);
        chk("rst_timeout", rr_to, 1'b0);
        m_addr = {30'h20, 30'h10};
        m_sel = 8'hFF;
        wb_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 18; i++) begin
            m_cyc = vecs[i].cyc; m_stb = vecs[i].stb; wb_ack = vecs[i].ack; wb_stall = vecs[i].stl;
            #1;
            chk($sformatf("vec%0d_grant", i), rr_grant, vecs[i].grant);
            chk($sformatf("vec%0d_wb_cyc", i), rr_cyc, vecs[i].wcyc);
            chk($sformatf("vec%0d_wb_stb", i), rr_stb, vecs[i].wstb);
            chk($sformatf("vec%0d_m_ack", i), rr_ack, vecs[i].mack);
            chk($sformatf("vec%0d_m_stall", i), rr_stall, vecs[i].mstall);
            chk($sformatf("vec%0d_wb_addr", i), rr_addr, vecs[i].addr);
            if (vecs[i].mack != 2'b00) chk($sformatf("vec%0d_m_data", i), rr_mdata, 32'hDEADBEEF);
            tick();
        end

        // master0 abandons a cycle with two strobes in flight; a late ack must go nowhere
        do_reset();
        m_cyc = 2'b01; tick();
        m_stb = 2'b01; tick(); tick();
        m_stb = 2'b00; m_cyc = 2'b00; #1;
        chk("drop_wb_cyc_now", rr_cyc, 1'b0);
        tick();
        chk("drop_grant", rr_grant, 2'b00);
        wb_ack = 1'b1; #1;
        chk("drop_stray_ack", rr_ack, 2'b00);
        chk("drop_wb_cyc", rr_cyc, 1'b0);
        tick();
        wb_ack = 1'b0;

        // watchdog: one strobe never acked
        do_reset();
        m_cyc = 2'b01; tick();
        m_stb = 2'b01; tick();
        m_stb = 2'b00;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("wd_wait%0d_to", c), rr_to, 1'b0);
            chk($sformatf("wd_wait%0d_cyc", c), rr_cyc, 1'b1);
            tick();
        end
        wb_ack = 1'b1; #1;
        chk("wd_pulse", rr_to, 1'b1);
        chk("wd_wb_cyc", rr_cyc, 1'b0);
        chk("wd_stall", rr_stall, 2'b11);
        chk("wd_ack", rr_ack, 2'b00);
        chk("wd_grant", rr_grant, 2'b01);
        tick();
        wb_ack = 1'b0; #1;
        chk("wd_pulse_end", rr_to, 1'b0);
        chk("drain_hold", rr_grant, 2'b01);
        tick();
        m_cyc = 2'b00; tick();
        chk("drain_exit", rr_grant, 2'b00);

        // reset in the middle of a three-deep burst from master1
        do_reset();
        m_cyc = 2'b10; tick();
        m_stb = 2'b10; tick(); tick(); tick();
        m_stb = 2'b00; reset = 1'b1; #1;
        chk("midrst_pre_cyc", rr_cyc, 1'b1);
        tick();
        chk("midrst_grant", rr_grant, 2'b00);
        chk("midrst_wb_cyc", rr_cyc, 1'b0);
        reset = 1'b0; m_cyc = 2'b11; tick();
        chk("midrst_first", rr_grant, 2'b01);

        // contention: round-robin alternates, fixed keeps master0 while it asks
        for (int fx = 0; fx < 2; fx++) begin
            do_reset();
            m_cyc = 2'b11; tick();
            for (int t = 0; t < 4; t++) begin
                g = fx ? fx_grant : rr_grant;
                chk($sformatf("alt%0d_grant%0d", fx, t), g, (fx == 1 || t % 2 == 0) ? 2'b01 : 2'b10);
                m_stb = g; tick();
                m_stb = 2'b00; wb_ack = 1'b1; #1;
                chk($sformatf("alt%0d_ack%0d", fx, t), fx ? fx_ack : rr_ack, g);
                tick();
                wb_ack = 1'b0; m_cyc = 2'b11 & ~g; tick();
                m_cyc = 2'b11; #1;
                chk($sformatf("alt%0d_idle%0d", fx, t), fx ? fx_grant : rr_grant, 2'b00);
                tick();
            end
        end

        // randomized traffic against the reference model, with ack-free windows to provoke timeouts
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = $urandom_range(0, 255) == 0;
            for (int k = 0; k < 2; k++)
                m_cyc[k] = m_cyc[k] ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 3) == 0);
            m_stb    = m_cyc & 2'($urandom);
            m_we     = 2'($urandom);
            m_sel    = 8'($urandom);
            m_addr   = {30'($urandom), 30'($urandom)};
            m_data   = {$urandom, $urandom};
            wb_ack   = (c % 300 < 100) ? 1'b0 : ($urandom_range(0, 2) == 0);
            wb_stall = $urandom_range(0, 3) == 0;
            wb_rdata = $urandom;
            #1;
            model_step();
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- N-master to 1-slave pipelined Wishbone (B4 pipelined) arbiter.
- Lets the fetch and mem bus masters, plus future DMA or debug masters, share one memory/peripheral slave port.
- Supports round-robin or fixed-priority grant, holds grant for a whole bus cycle (cyc), tracks outstanding strobes and aborts hung cycles with a watchdog.
- Sits between core stage bus ports and the system memory device.

Parameters:
- NUM_MASTERS, 2, number of master ports (>=2).
- ADDR_WIDTH, 30, word address width.
- DATA_WIDTH, 32, data width; SEL_WIDTH = DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, max accepted-but-unacked strobes per cycle.
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed (lowest index wins).
- TIMEOUT_CYCLES, 255, cycles without ack while outstanding>0 before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- i_m_cyc  in  NUM_MASTERS  per-master cyc.
- i_m_stb  in  NUM_MASTERS  per-master stb.
- i_m_we  in  NUM_MASTERS  per-master we.
- i_m_sel  in  NUM_MASTERS*SEL_WIDTH  packed; master k at [k*SEL_WIDTH +: SEL_WIDTH].
- i_m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed, same indexing.
- i_m_data  in  NUM_MASTERS*DATA_WIDTH  packed write data.
- o_m_ack  out  NUM_MASTERS  per-master ack.
- o_m_stall  out  NUM_MASTERS  per-master stall.
- o_m_data  out  DATA_WIDTH  read data, broadcast; valid only with that master's ack.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  slave bus controls.
- o_wb_sel  out  SEL_WIDTH  slave byte selects.
- o_wb_addr  out  ADDR_WIDTH  slave address.
- o_wb_data  out  DATA_WIDTH  slave write data.
- i_wb_ack, i_wb_stall  in  1 each  slave responses.
- i_wb_data  in  DATA_WIDTH  slave read data.
- o_grant  out  NUM_MASTERS  one-hot registered grant; all zero when idle.
- o_timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- States: IDLE, GRANTED, DRAIN.
- Reset: state IDLE, o_grant=0, outstanding=0, watchdog=0, o_timeout=0, RR pointer = NUM_MASTERS-1 so master 0 wins first. In IDLE all slave outputs are 0, o_m_ack=0 and o_m_stall=all 1s.
- IDLE -> GRANTED: if any i_m_cyc is high, select a winner and register it into o_grant.
  - Round-robin searches from pointer+1 with wrap-around; fixed mode picks the lowest index.
  - Pointer updates to the winner.
  - Slave bus is driven from the next cycle, so grant latency is 1 cycle.
- GRANTED, slave outputs: combinational mux of the granted master's cyc/stb/we/sel/addr/data.
- GRANTED, granted master: o_m_stall = i_wb_stall OR (outstanding==MAX_OUTSTANDING); o_m_ack = i_wb_ack.
- GRANTED, stb gating: when outstanding==MAX_OUTSTANDING, o_wb_stb is forced 0.
- GRANTED, non-granted masters: stall=1, ack=0.
- Outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on o_wb_stb & !i_wb_stall; -1 on i_wb_ack; both in the same cycle leaves it unchanged.
  - An ack with outstanding==0 is dropped and not forwarded.
- Release: granted i_m_cyc falls -> IDLE next edge. o_wb_cyc follows combinationally, so the slave sees the abort.
  - outstanding is cleared and later acks are dropped.
  - Minimum one idle cycle between grants.
- Watchdog: counts while GRANTED and outstanding>0 with no ack; any ack clears it.
  - On reaching TIMEOUT_CYCLES: enter DRAIN, pulse o_timeout, force o_wb_cyc=0, clear outstanding.
  - Granted master sees stall=1 and ack=0 from then on.
- DRAIN -> IDLE once the granted i_m_cyc is low. The master is expected to drop cyc; DRAIN holds indefinitely otherwise.
- Reset mid-cycle: state, counters and grant return to reset values on the next edge; slave cyc drops with them.
- Simultaneous requests in IDLE: only one winner; the others stay stalled.
- A new requester in GRANTED does not preempt.

Decomposition:
- Package wb_arb_pkg: state enum arb_state_t {IDLE, GRANTED, DRAIN}, and constants PRIO_RR=0 and PRIO_FIXED=1.
- Sub-module rr_picker: combinational, parameter N. Inputs are the request vector, pointer and mode; output is a one-hot winner. Reused by future interrupt arbitration.

Test Plan:
- Reset then master0 cyc/stb one read at addr 0x10 -> o_grant=01 one cycle later; o_wb_addr=0x10; slave ack+data 0xDEADBEEF goes to master0 ack with o_m_data=0xDEADBEEF.
- Both masters request every cycle, RR mode, 4 back-to-back single-beat cycles -> grants 0,1,0,1 with one idle cycle between each. In fixed mode -> 0,0,0,0 while master0 keeps requesting.
- Master1 issues 6 pipelined stb with slave stall=0 and no ack, MAX_OUTSTANDING=4 -> exactly 4 accepted, then master1 stalled. One ack -> 5th stb accepted.
- Master0 drops cyc with 2 outstanding -> IDLE next edge, o_wb_cyc=0. Stray ack on the next cycle -> no o_m_ack on any port.
- TIMEOUT_CYCLES=8, one stb, never ack -> o_timeout pulses at 8 cycles, o_wb_cyc=0, DRAIN until master drops cyc, then IDLE.
- Reset asserted mid-burst with 3 outstanding -> next cycle o_grant=0, o_wb_cyc=0. First post-reset grant goes to master 0.
